// File: rtl/scarv_cop_mem_responder.sv
// rtl/scarv_cop_mem_responder.sv - memory-side responder for the coprocessor load/store bus
//
// Word-addressed SRAM answering cop_mem_* requests: one address phase, then a
// data phase that may be stretched by fixed wait states and stall injection.
// A backdoor port gives preload/inspection access when the bus is quiet.
//
// Ports:
//   g_clk, g_resetn        clock, synchronous active-low reset
//   cop_mem_cen/wen/addr/wdata/ben   request inputs (sampled in address phase)
//   cop_mem_rdata/stall/error        response outputs
//   stall_req, err_inject            stall and error injection
//   bd_en/wen/idx/wdata, bd_ack/rdata backdoor access
//   rsp_count                         completed responses, wrapping
module scarv_cop_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             cop_mem_cen,
  input  logic             cop_mem_wen,
  input  logic [31:0]      cop_mem_addr,
  input  logic [31:0]      cop_mem_wdata,
  input  logic [3:0]       cop_mem_ben,
  output logic [31:0]      cop_mem_rdata,
  output logic             cop_mem_stall,
  output logic             cop_mem_error,
  input  logic             stall_req,
  input  logic             err_inject,
  input  logic             bd_en,
  input  logic             bd_wen,
  input  logic [IDX_W-1:0] bd_idx,
  input  logic [31:0]      bd_wdata,
  output logic             bd_ack,
  output logic [31:0]      bd_rdata,
  output logic [31:0]      rsp_count
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, DATA} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [31:0] cap_addr;
  logic        cap_wen;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_ben;
  logic [31:0] rsp_cnt;

  logic [31:0] mem [DEPTH_WORDS];

  logic             rsp;
  logic             addr_phase;
  logic             err;
  logic             in_range;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             commit;

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range too.
  assign off      = cap_addr - BASE_ADDR;
  assign in_range = (off >> (IDX_W + 2)) == 32'd0;
  assign idx      = off[IDX_W+1:2];

  // Outputs are gated by g_resetn so they read zero while reset is held,
  // even before the clock edge that clears the state.
  assign rsp        = g_resetn && (state == DATA) && (wait_cnt == 4'd0) && !stall_req;
  assign addr_phase = g_resetn && cop_mem_cen && ((state == IDLE) || rsp);
  assign err        = err_inject || (cap_addr[1:0] != 2'b00) || !in_range;
  assign commit     = rsp && cap_wen && !err;

  assign cop_mem_stall = g_resetn && (state == DATA) && !rsp;
  assign cop_mem_error = rsp && err;
  assign rsp_count     = g_resetn ? rsp_cnt : 32'd0;

  always_comb begin
    cop_mem_rdata = 32'd0;
    if (rsp && !err && !cap_wen) begin
      cop_mem_rdata = mem[idx];
    end
  end

  // Backdoor only gets the array when the bus is idle and not requesting.
  assign bd_ack = g_resetn && bd_en && (state == IDLE) && !cop_mem_cen;

  always_comb begin
    bd_rdata = 32'd0;
    if (bd_ack) begin
      bd_rdata = mem[bd_idx];
    end
  end

  always_comb begin
    state_nxt = state;
    if (addr_phase) begin
      state_nxt = DATA;
    end else if (rsp) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      cap_addr  <= 32'd0;
      cap_wen   <= 1'b0;
      cap_wdata <= 32'd0;
      cap_ben   <= 4'd0;
      rsp_cnt   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (addr_phase) begin
        cap_addr  <= cop_mem_addr;
        cap_wen   <= cop_mem_wen;
        cap_wdata <= cop_mem_wdata;
        cap_ben   <= cop_mem_ben;
        wait_cnt  <= WAIT_INIT;
      end else if ((state == DATA) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (rsp) begin
        rsp_cnt <= rsp_cnt + 32'd1;
      end
    end
  end

  // Array is deliberately not reset. Bus commit and backdoor write are
  // mutually exclusive: one needs DATA, the other IDLE.
  always_ff @(posedge g_clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_ben[i]) begin
          mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
    if (bd_ack && bd_wen) begin
      mem[bd_idx] <= bd_wdata;
    end
  end

endmodule

// File: doc/scarv_cop_mem_responder.md
Name: scarv_cop_mem_responder

Overview:
- Memory-side responder for the coprocessor load/store bus (cop_mem_*): the far end of the coprocessor memory initiator.
- Backs a word-addressed SRAM array and answers each request with a one-cycle address phase, then a data phase.
- The data phase supports configurable wait states, external stall injection and error signalling.
- Used as the integration/verification memory model and as a tightly-coupled scratchpad; exposes a backdoor port for preload/inspection.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*4).
- WAIT_CYCLES, 0, fixed stall cycles inserted at the start of every data phase (0..15).

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  synchronous active-low reset.
- cop_mem_cen  in  1  request valid / chip enable.
- cop_mem_wen  in  1  1 = write, 0 = read.
- cop_mem_addr  in  32  byte address, expected word aligned.
- cop_mem_wdata  in  32  write data.
- cop_mem_ben  in  4  write byte enables.
- cop_mem_rdata  out  32  read data, valid in response cycle.
- cop_mem_stall  out  1  data phase not complete.
- cop_mem_error  out  1  transaction failed, valid in response cycle.
- stall_req  in  1  bench/arbiter stall injection.
- err_inject  in  1  force error on the current response.
- bd_en  in  1  backdoor access request.
- bd_wen  in  1  backdoor write.
- bd_idx  in  $clog2(DEPTH_WORDS)  backdoor word index.
- bd_wdata  in  32  backdoor write data (full word).
- bd_ack  out  1  backdoor access performed this cycle.
- bd_rdata  out  32  backdoor read data, valid when bd_ack.
- rsp_count  out  32  completed responses (good + error), wraps at 2^32.

Behaviour:
- Reset: g_resetn sampled on posedge g_clk, synchronous, active-low. FSM=IDLE, wait counter=0, rsp_count=0, captured request cleared. All outputs are 0 during and after reset. Array contents are not reset.
- Reset mid-transaction: the outstanding transaction is dropped and no write is committed.
- FSM has two states, IDLE and DATA.
- Address phase: any cycle with cop_mem_cen=1 in IDLE, or in the response cycle of DATA.
  - Captures addr, wen, wdata and ben.
  - Loads wait counter with WAIT_CYCLES.
  - Next state is DATA.
- DATA, cycle by cycle:
  - counter != 0: stall=1, counter decrements, request inputs ignored.
  - counter == 0 and stall_req=1: stall=1, counter held.
  - counter == 0 and stall_req=0: response cycle, stall=0.
- Response cycle outputs:
  - error=1 if err_inject, captured addr[1:0] != 0, or addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - Read without error: rdata = array[(addr-BASE_ADDR)>>2], driven combinationally from the current array state.
  - Write, or any error: rdata=0.
  - rsp_count increments by 1.
- Write commit: on the clock edge ending the response cycle, and only if error=0. Each byte lane i is written where ben[i]=1. ben=4'b0000 is a legal no-op write with no error.
- Ordering: a read whose response cycle follows a write's response cycle returns the written data.
- Back-to-back: if cop_mem_cen=1 during the response cycle, that cycle is also the next address phase (zero bubble). Otherwise next state is IDLE.
- Throughput with WAIT_CYCLES=0 and no stall_req: one transaction per cycle.
- cop_mem_cen dropping while in DATA: ignored. The captured transaction still completes, including its write.
- Outside response cycles: stall=0 in IDLE; rdata=0 and error=0 everywhere.
- Backdoor arbitration: bd_ack=bd_en && FSM==IDLE && !cop_mem_cen. The bus has priority, so the backdoor waits.
- Backdoor read: bd_rdata = array[bd_idx] in the ack cycle, else 0.
- Backdoor write: commits full word at the end of the ack cycle.
- Latency, request to response: WAIT_CYCLES + number of stall_req cycles + 1.

Test Plan:
- Preload via backdoor idx 3 = 32'hDEAD_BEEF; bus read addr 0xC with WAIT=0 -> cycle+1: stall=0, error=0, rdata=32'hDEADBEEF, rsp_count=1.
- Write addr 0x10, wdata 32'h1122_3344, ben=4'b0101, then read 0x10 back-to-back over preloaded 0 -> no bubble between the two; read returns 32'h0022_0044.
- WAIT_CYCLES=3, read 0x0 -> stall high for exactly 3 cycles, response on 4th cycle after address phase; stall_req held 2 extra cycles -> response on 6th.
- Read 0x2 (misaligned) and read BASE_ADDR+4*DEPTH_WORDS -> error=1, rdata=0. Write to out-of-range address -> error=1, array unchanged (backdoor check). err_inject on a valid write -> error=1, no commit.
- bd_en held while bus issues 3 back-to-back reads -> bd_ack=0 until the first IDLE cycle with cen=0, then a single ack with correct bd_rdata.
- Reset asserted during a WAIT=3 write's stall -> outputs 0 next cycle, target word unchanged, rsp_count=0, next read serviced normally.
